// File: rtl/adc_conv_scheduler.sv
// ADC conversion sequencer: arbitrates a periodic timer (A) and a software
// single-shot request (B), drives the ADC start/config handshake, and queues tagged results.
module adc_conv_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned START_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic [15:0] period_in,
  input  logic        sw_req_in,
  input  logic [15:0] cfg1_a_in,
  input  logic [15:0] cfg2_a_in,
  input  logic [15:0] cfg1_b_in,
  input  logic [15:0] cfg2_b_in,
  output logic        start_conversion_out,
  output logic [15:0] config_1_out,
  output logic [15:0] config_2_out,
  input  logic        conversion_finished_in,
  input  logic [15:0] result_in,
  output logic [16:0] data_out,
  output logic        data_valid_out,
  input  logic        data_ready_in,
  output logic        busy_out,
  output logic        overflow_out,
  output logic        timeout_out,
  input  logic        clear_status_in
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (START_LEN > 1) ? $clog2(START_LEN + 1) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DW = 17;

  typedef enum logic [2:0] {
    IDLE, START, WAIT_LOW, WAIT_DONE, CAPTURE
  } state_t;

  state_t          state, state_d;
  logic [SW-1:0]   scnt, scnt_d;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic            fin_s1, fin_s2, fin_d;
  logic            pend_a, pend_b, grant_a, grant_b, tag;
  logic [15:0]     pcnt, per_max;
  logic            tick, fifo_wr, timeout_set;

  // Next-state logic for the conversion handshake
  always_comb begin
    state_d     = state;
    scnt_d      = scnt;
    tcnt_d      = tcnt;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    fifo_wr     = 1'b0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        scnt_d = '0;
        tcnt_d = '0;
        if (pend_b) begin
          grant_b = 1'b1;
          state_d = START;
        end else if (pend_a) begin
          grant_a = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (scnt == SW'(START_LEN - 1)) state_d = WAIT_LOW;
        else scnt_d = scnt + SW'(1);
      end
      WAIT_LOW: begin
        tcnt_d = tcnt + TW'(1);
        if (!fin_s2) begin
          state_d = WAIT_DONE;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
        end
      end
      WAIT_DONE: begin
        tcnt_d = tcnt + TW'(1);
        if (fin_s2 && !fin_d) begin
          state_d = CAPTURE;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
        end
      end
      CAPTURE: begin
        fifo_wr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      scnt                 <= '0;
      tcnt                 <= '0;
      start_conversion_out <= 1'b0;
      busy_out             <= 1'b0;
      config_1_out         <= '0;
      config_2_out         <= '0;
      tag                  <= 1'b0;
    end else begin
      state                <= state_d;
      scnt                 <= scnt_d;
      tcnt                 <= tcnt_d;
      start_conversion_out <= (state == START);
      busy_out             <= (state_d != IDLE);
      if (grant_b) begin
        config_1_out <= cfg1_b_in;
        config_2_out <= cfg2_b_in;
        tag          <= 1'b1;
      end else if (grant_a) begin
        config_1_out <= cfg1_a_in;
        config_2_out <= cfg2_a_in;
        tag          <= 1'b0;
      end
    end
  end

  // Finished is asynchronous to clk; fin_d provides the rising-edge reference
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_s1 <= 1'b0;
      fin_s2 <= 1'b0;
      fin_d  <= 1'b0;
    end else begin
      fin_s1 <= conversion_finished_in;
      fin_s2 <= fin_s1;
      fin_d  <= fin_s2;
    end
  end

  // A new tick wins over a same-cycle grant so no request is lost
  assign per_max = (period_in == 16'd0) ? 16'd0 : period_in - 16'd1;
  assign tick    = enable_in && (pcnt >= per_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt   <= '0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      pend_b <= (pend_b && !grant_b) || sw_req_in;
      if (!enable_in) begin
        pcnt   <= '0;
        pend_a <= 1'b0;
      end else begin
        pcnt   <= tick ? 16'd0 : pcnt + 16'd1;
        pend_a <= (pend_a && !grant_a) || tick;
      end
    end
  end

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_d;
  logic [CW-1:0] count, count_d, remain;
  logic          pop, push, full, ovf_set;
  logic [DW-1:0] wdata;

  assign wdata    = {tag, result_in};
  assign pop      = data_valid_out && data_ready_in;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign push     = fifo_wr && (!full || pop);
  assign ovf_set  = fifo_wr && full && !pop;
  assign remain   = count - CW'(pop);
  assign count_d  = remain + CW'(push);
  assign rd_ptr_d = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // data_out is a registered copy of the head entry after this cycle's push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_valid_out <= 1'b0;
      data_out       <= '0;
      overflow_out   <= 1'b0;
      timeout_out    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr         <= rd_ptr_d;
      count          <= count_d;
      data_valid_out <= (count_d != '0);
      if (push && remain == '0) data_out <= wdata;
      else if (remain != '0)    data_out <= mem[rd_ptr_d];
      overflow_out   <= ovf_set || (overflow_out && !clear_status_in);
      timeout_out    <= timeout_set || (timeout_out && !clear_status_in);
    end
  end

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler with a behavioural ADC model and
// a result scoreboard popped whenever the DUT hands out a FIFO entry.
module tb_adc_conv_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_in, sw_req_in, data_ready_in, clear_status_in;
  logic [15:0] period_in, cfg1_a_in, cfg2_a_in, cfg1_b_in, cfg2_b_in;
  logic        start_conversion_out, conversion_finished_in;
  logic [15:0] config_1_out, config_2_out, result_in;
  logic [16:0] data_out;
  logic        data_valid_out, busy_out, overflow_out, timeout_out;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  adc_conv_scheduler #(.FIFO_DEPTH(4), .START_LEN(4), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .period_in(period_in),
    .sw_req_in(sw_req_in), .cfg1_a_in(cfg1_a_in), .cfg2_a_in(cfg2_a_in),
    .cfg1_b_in(cfg1_b_in), .cfg2_b_in(cfg2_b_in),
    .start_conversion_out(start_conversion_out), .config_1_out(config_1_out),
    .config_2_out(config_2_out), .conversion_finished_in(conversion_finished_in),
    .result_in(result_in), .data_out(data_out), .data_valid_out(data_valid_out),
    .data_ready_in(data_ready_in), .busy_out(busy_out), .overflow_out(overflow_out),
    .timeout_out(timeout_out), .clear_status_in(clear_status_in)
  );

  // ADC model: returns config_2 as the result adc_delay cycles after start falls
  logic        adc_fin, adc_busy, adc_hang;
  logic [15:0] adc_res;
  int          adc_cnt, adc_delay;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_fin <= 1'b0; adc_busy <= 1'b0; adc_cnt <= 0; adc_res <= '0;
    end else if (start_conversion_out) begin
      adc_fin <= 1'b0; adc_busy <= 1'b1; adc_cnt <= adc_delay;
    end else if (adc_busy && !adc_hang) begin
      if (adc_cnt <= 1) begin
        adc_fin <= 1'b1; adc_res <= config_2_out; adc_busy <= 1'b0;
      end else adc_cnt <= adc_cnt - 1;
    end
  end
  assign conversion_finished_in = adc_fin;
  assign result_in              = adc_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: the pop happens on the next rising edge
  always @(negedge clk) begin
    if (rst === 1'b0 && data_valid_out === 1'b1 && data_ready_in === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_output", 32'(data_out), 32'hFFFF_FFFF);
      else check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input string tag, input int budget, output int waited);
    logic prev, found;
    waited = 0;
    found  = 1'b0;
    prev   = start_conversion_out;
    while (waited < budget && !found) begin
      step();
      waited++;
      if (start_conversion_out === 1'b1 && prev !== 1'b1) found = 1'b1;
      prev = start_conversion_out;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_out !== 1'b0 && n < 6000) begin step(); n++; end
    check(tag, 32'(busy_out), 32'd0);
  endtask

  task automatic wait_fin(input string tag);
    int n = 0;
    while (adc_fin !== 1'b0 && n < 100) begin step(); n++; end
    n = 0;
    while (adc_fin !== 1'b1 && n < 500) begin step(); n++; end
    check(tag, 32'(adc_fin), 32'd1);
  endtask

  task automatic do_req(input string tag);
    sw_req_in = 1'b1;
    step();
    sw_req_in = 1'b0;
    step();
    wait_idle(tag);
  endtask

  initial begin
    int len, w, rises;
    rst = 1'b1;
    enable_in = 0; sw_req_in = 0; data_ready_in = 1; clear_status_in = 0;
    period_in = 16'd0;
    cfg1_a_in = 16'h0A01; cfg2_a_in = 16'h0AAA;
    cfg1_b_in = 16'h0C05; cfg2_b_in = 16'h1234;
    adc_delay = 50; adc_hang = 1'b0;
    repeat (3) step();
    check("rst_start", 32'(start_conversion_out), 0);
    check("rst_cfg1", 32'(config_1_out), 0);
    check("rst_cfg2", 32'(config_2_out), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_valid", 32'(data_valid_out), 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_flags", {30'd0, overflow_out, timeout_out}, 0);
    rst = 1'b0;
    step();

    // Single shot: latency of start/config and capture
    exp_q.push_back(17'h1_1234);
    sw_req_in = 1'b1;
    step();
    sw_req_in = 1'b0;
    step();
    check("ss_start_n1", 32'(start_conversion_out), 0);
    check("ss_busy_n1", 32'(busy_out), 1);
    step();
    check("ss_start_n2", 32'(start_conversion_out), 1);
    check("ss_cfg1", 32'(config_1_out), 32'h0C05);
    check("ss_cfg2", 32'(config_2_out), 32'h1234);
    len = 1;
    step();
    while (start_conversion_out === 1'b1 && len < 20) begin len++; step(); end
    check("ss_pulse_len", len, 4);
    wait_fin("ss_fin_seen");
    repeat (3) step();
    check("ss_valid_k2", 32'(data_valid_out), 0);
    step();
    check("ss_valid_k3", 32'(data_valid_out), 1);
    check("ss_data_k3", 32'(data_out), 32'h1_1234);
    wait_idle("ss_idle");
    step();
    check("ss_drained", exp_q.size(), 0);

    // Periodic requester, dropped mid-conversion
    period_in = 16'd200;
    repeat (3) exp_q.push_back({1'b0, 16'h0AAA});
    enable_in = 1'b1;
    wait_rise("per_rise1", 400, w);
    check("per_cfg1", 32'(config_1_out), 32'h0A01);
    wait_rise("per_rise2", 400, w);
    check("per_interval1", w, 200);
    wait_rise("per_rise3", 400, w);
    check("per_interval2", w, 200);
    repeat (10) step();
    enable_in = 1'b0;
    wait_idle("per_idle");
    rises = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (start_conversion_out === 1'b1) rises++;
    end
    check("per_no_more_starts", rises, 0);
    check("per_drained", exp_q.size(), 0);

    // Arbitration: A tick and B request on the same edge
    period_in = 16'd1000;
    cfg1_b_in = 16'h0B01; cfg2_b_in = 16'h0B02;
    cfg2_a_in = 16'h0A02;
    exp_q.push_back({1'b1, 16'h0B02});
    exp_q.push_back({1'b0, 16'h0A02});
    enable_in = 1'b1;
    repeat (999) step();
    sw_req_in = 1'b1;
    step();
    sw_req_in = 1'b0;
    wait_rise("arb_rise_b", 20, w);
    check("arb_b_cfg1", 32'(config_1_out), 32'h0B01);
    check("arb_b_cfg2", 32'(config_2_out), 32'h0B02);
    wait_rise("arb_rise_a", 300, w);
    check("arb_a_cfg1", 32'(config_1_out), 32'h0A01);
    check("arb_a_cfg2", 32'(config_2_out), 32'h0A02);
    wait_idle("arb_idle");
    enable_in = 1'b0;
    repeat (5) step();
    check("arb_cfg_hold", 32'(config_1_out), 32'h0A01);
    check("arb_drained", exp_q.size(), 0);

    // Overflow: 5 writes into a 4-deep FIFO with no reader
    data_ready_in = 1'b0;
    adc_delay = 10;
    for (int i = 1; i <= 5; i++) begin
      cfg2_b_in = 16'h0100 + 16'(i);
      if (i <= 4) exp_q.push_back({1'b1, cfg2_b_in});
      do_req("ovf_idle");
    end
    step();
    check("ovf_flag", 32'(overflow_out), 1);
    check("ovf_valid", 32'(data_valid_out), 1);
    check("ovf_head", 32'(data_out), 32'h1_0101);
    clear_status_in = 1'b1;
    step();
    clear_status_in = 1'b0;
    check("ovf_cleared", 32'(overflow_out), 0);
    cfg2_b_in = 16'h0106;
    exp_q.push_back(17'h1_0106);
    sw_req_in = 1'b1;
    step();
    sw_req_in = 1'b0;
    wait_fin("ovf_fin6");
    repeat (3) step();
    data_ready_in = 1'b1;
    step();
    data_ready_in = 1'b0;
    step();
    check("ovf_push_pop_no_drop", 32'(overflow_out), 0);
    wait_idle("ovf_idle6");
    data_ready_in = 1'b1;
    w = 0;
    while (data_valid_out === 1'b1 && w < 20) begin step(); w++; end
    check("ovf_drain_empty", 32'(data_valid_out), 0);
    check("ovf_drained", exp_q.size(), 0);

    // Timeout: ADC never finishes
    adc_hang = 1'b1;
    cfg2_b_in = 16'h0333;
    sw_req_in = 1'b1;
    step();
    sw_req_in = 1'b0;
    wait_rise("to_rise", 10, w);
    w = 0;
    while (start_conversion_out === 1'b1 && w < 20) begin step(); w++; end
    w = 0;
    while (timeout_out !== 1'b1 && w < 5000) begin step(); w++; end
    check("to_flag", 32'(timeout_out), 1);
    check("to_latency_window", 32'(w >= 4090 && w <= 4100), 1);
    check("to_idle", 32'(busy_out), 0);
    check("to_no_write", 32'(data_valid_out), 0);
    adc_hang = 1'b0;
    clear_status_in = 1'b1;
    step();
    clear_status_in = 1'b0;
    check("to_cleared", 32'(timeout_out), 0);
    cfg2_b_in = 16'h0444;
    exp_q.push_back(17'h1_0444);
    do_req("to_next_idle");
    repeat (3) step();
    check("to_next_drained", exp_q.size(), 0);

    // Reset during START with two entries and a pending request
    data_ready_in = 1'b0;
    cfg2_b_in = 16'h0201;
    do_req("rm_idle1");
    cfg2_b_in = 16'h0202;
    do_req("rm_idle2");
    step();
    check("rm_head", 32'(data_out), 32'h1_0201);
    sw_req_in = 1'b1;
    step();
    sw_req_in = 1'b0;
    wait_rise("rm_rise", 10, w);
    sw_req_in = 1'b1;
    step();
    sw_req_in = 1'b0;
    check("rm_in_start", 32'(start_conversion_out), 1);
    #2 rst = 1'b1;
    #1;
    check("rm_start", 32'(start_conversion_out), 0);
    check("rm_busy", 32'(busy_out), 0);
    check("rm_valid", 32'(data_valid_out), 0);
    check("rm_data", 32'(data_out), 0);
    check("rm_cfg", {config_1_out, config_2_out}, 0);
    step();
    rst = 1'b0;
    data_ready_in = 1'b1;
    rises = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (start_conversion_out === 1'b1 || data_valid_out === 1'b1) rises++;
    end
    check("rm_nothing_survives", rises, 0);
    check("rm_final_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
